mem_rw_bytes: RTL and testbench

Parametrised byte-addressable scratch memory with a single request/ready handshake for both reads and writes, per-byte write enables, address-dependent wait states, and a combinational debug read port. It is the next-generation data memory for the simulation models: word width and depth are generic, and it adds a registered read path and partial-word writes.

---
 rtl/mem_rw_bytes.sv | 119 +++++++++++
 tb/tb_mem_rw_bytes.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_rw_bytes.sv
// mem_rw_bytes: byte-addressable scratch memory, request/ready handshake, byte enables, combinational debug port.
// Define MEM_RW_WAIT_EN for address-dependent busy time (address[1:0]+1 cycles); otherwise every access takes one cycle.
module mem_rw_bytes #(
  parameter int unsigned SIZE          = 256,
  parameter int unsigned ADDRESS_WIDTH = 8,
  parameter int unsigned DATA_BYTES    = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       rwn,
  input  logic [ADDRESS_WIDTH-1:0]   address,
  input  logic [8*DATA_BYTES-1:0]    data_in,
  input  logic [DATA_BYTES-1:0]      byte_en,
  output logic                       ready,
  output logic [8*DATA_BYTES-1:0]    rdata,
  output logic                       rvalid,
  input  logic [ADDRESS_WIDTH-1:0]   a_adr,
  output logic [8*DATA_BYTES-1:0]    a_data
);

  localparam int unsigned DATA_W = 8 * DATA_BYTES;
  localparam int unsigned IDX_W  = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int unsigned BE_W   = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t                     state;
  logic [1:0]                 count;
  logic [1:0]                 wait_load;
  logic [ADDRESS_WIDTH-1:0]   addr_q;
  logic                       rwn_q;
  logic [DATA_W-1:0]          data_q;
  logic [DATA_BYTES-1:0]      be_q;
  logic                       do_write;
  logic [7:0]                 mem [SIZE];

  // Byte index of lane k for a word at byte address a, wrapped modulo SIZE.
  function automatic logic [IDX_W-1:0] wrap(input logic [ADDRESS_WIDTH-1:0] a, input int unsigned k);
    int unsigned sum;
    sum = (32'(a) + k) % SIZE;
    return IDX_W'(sum);
  endfunction

`ifdef MEM_RW_WAIT_EN
  assign wait_load = address[1:0];
`else
  assign wait_load = 2'd0;
`endif

  assign do_write = (state == BUSY) && (count == 2'd0) && !rwn_q;

  // Handshake FSM, request latch and registered read path.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      count  <= 2'd0;
      ready  <= 1'b1;
      rvalid <= 1'b0;
      rdata  <= '0;
      addr_q <= '0;
      rwn_q  <= 1'b0;
      data_q <= '0;
      be_q   <= '0;
    end else begin
      rvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            addr_q <= address;
            rwn_q  <= rwn;
            data_q <= data_in;
            be_q   <= byte_en;
            count  <= wait_load;
            state  <= BUSY;
            ready  <= 1'b0;
          end
        end
        BUSY: begin
          if (count != 2'd0) begin
            count <= count - 2'd1;
          end else begin
            state <= IDLE;
            ready <= 1'b1;
            if (rwn_q) begin
              for (int unsigned k = 0; k < DATA_BYTES; k++) begin
                rdata[8*k +: 8] <= mem[wrap(addr_q, k)];
              end
              rvalid <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  // Byte storage; reset clears every byte, so an aborted write leaves nothing behind.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < SIZE; i++) begin
        mem[i] <= 8'h00;
      end
    end else if (do_write) begin
      for (int unsigned k = 0; k < DATA_BYTES; k++) begin
        if (be_q[BE_W'(k)]) begin
          mem[wrap(addr_q, k)] <= data_q[8*k +: 8];
        end
      end
    end
  end

  always_comb begin
    a_data = '0;
    for (int unsigned k = 0; k < DATA_BYTES; k++) begin
      a_data[8*k +: 8] = mem[wrap(a_adr, k)];
    end
  end

endmodule

// File: tb/tb_mem_rw_bytes.sv
// tb_mem_rw_bytes: scoreboard bench for mem_rw_bytes (default parameters); follows MEM_RW_WAIT_EN when defined.
module tb_mem_rw_bytes;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        rwn;
  logic [7:0]  address;
  logic [31:0] data_in;
  logic [3:0]  byte_en;
  logic        ready;
  logic [31:0] rdata;
  logic        rvalid;
  logic [7:0]  a_adr;
  logic [31:0] a_data;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  model [256];
  logic [31:0] sb [$];

  mem_rw_bytes #(.SIZE(256), .ADDRESS_WIDTH(8), .DATA_BYTES(4)) dut (
    .clk(clk), .reset(reset), .start(start), .rwn(rwn), .address(address),
    .data_in(data_in), .byte_en(byte_en), .ready(ready), .rdata(rdata),
    .rvalid(rvalid), .a_adr(a_adr), .a_data(a_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model_word(input logic [7:0] a);
    logic [31:0] w;
    logic [7:0]  idx;
    w = '0;
    for (int k = 0; k < 4; k++) begin
      idx = a + 8'(k);
      w[8*k +: 8] = model[idx];
    end
    return w;
  endfunction

  task automatic model_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
    logic [7:0] idx;
    for (int k = 0; k < 4; k++) begin
      idx = a + 8'(k);
      if (be[k]) model[idx] = d[8*k +: 8];
    end
  endtask

  function automatic int exp_busy(input logic [7:0] a);
    int w;
    w = int'(a[1:0]);
`ifndef MEM_RW_WAIT_EN
    w = 0;
`endif
    return w + 1;
  endfunction

  // Issue one request from an IDLE sample point and follow it to completion.
  task automatic req(input logic rd, input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
    int n;
    logic [31:0] e;
    checks++;
    if (ready !== 1'b1) begin
      failures++;
      $display("FAIL req_ready addr=%h got=%b exp=1", a, ready);
    end
    start = 1'b1; rwn = rd; address = a; data_in = d; byte_en = be;
    if (rd) sb.push_back(model_word(a));
    else model_write(a, d, be);
    tick();
    start = 1'b0;
    n = 0;
    while (ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (n !== exp_busy(a)) begin
      failures++;
      $display("FAIL busy_len addr=%h got=%0d exp=%0d", a, n, exp_busy(a));
    end
    checks++;
    if (rvalid !== rd) begin
      failures++;
      $display("FAIL rvalid_at_done addr=%h got=%b exp=%b", a, rvalid, rd);
    end
    if (rvalid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL rdata_unexpected addr=%h got=%h exp=none", a, rdata);
      end else begin
        e = sb.pop_front();
        if (rdata !== e) begin
          failures++;
          $display("FAIL rdata addr=%h got=%h exp=%h", a, rdata, e);
        end
      end
    end
  endtask

  task automatic peek(input string name, input logic [7:0] a, input logic [31:0] exp);
    a_adr = a;
    #1;
    checks++;
    if (a_data !== exp) begin
      failures++;
      $display("FAIL %s a_adr=%h got=%h exp=%h", name, a, a_data, exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; rwn = 1'b1; address = '0; data_in = '0; byte_en = '0; a_adr = '0;
    for (int i = 0; i < 256; i++) model[i] = 8'h00;
    sb.delete();
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    peek("reset_a_data", 8'h10, 32'h0000_0000);
    checks++;
    if (ready !== 1'b1 || rvalid !== 1'b0 || rdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_outputs got ready=%b rvalid=%b rdata=%h exp ready=1 rvalid=0 rdata=0", ready, rvalid, rdata);
    end
  endtask

  task automatic test_full_word();
    req(1'b0, 8'h20, 32'hDEAD_BEEF, 4'b1111);
    peek("full_write_peek", 8'h20, 32'hDEAD_BEEF);
    req(1'b1, 8'h20, 32'h0, 4'b0000);
    tick();
    checks++;
    if (rvalid !== 1'b0 || rdata !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL rvalid_pulse got rvalid=%b rdata=%h exp rvalid=0 rdata=deadbeef", rvalid, rdata);
    end
  endtask

  task automatic test_partial_write();
    req(1'b0, 8'h24, 32'h5A5A_5A5A, 4'b1111);
    req(1'b0, 8'h23, 32'h1122_3344, 4'b0101);
    peek("partial_peek", 8'h23, 32'h5A22_5A44);
    peek("partial_model", 8'h22, model_word(8'h22));
    req(1'b1, 8'h23, 32'h0, 4'b1111);
  endtask

  task automatic test_wrap();
    req(1'b0, 8'hFE, 32'hA1B2_C3D4, 4'b1111);
    peek("wrap_peek_fe", 8'hFE, 32'hA1B2_C3D4);
    peek("wrap_peek_00", 8'h00, 32'h0000_A1B2);
    req(1'b1, 8'hFE, 32'h0, 4'b0000);
  endtask

  task automatic test_start_while_busy();
    int n;
    start = 1'b1; rwn = 1'b0; address = 8'h03; data_in = 32'hCAFE_F00D; byte_en = 4'b1111;
    model_write(8'h03, 32'hCAFE_F00D, 4'b1111);
    tick();
    address = 8'h10; data_in = 32'h0BAD_BEEF;
    n = 0;
    while (ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (n !== exp_busy(8'h03)) begin
      failures++;
      $display("FAIL busy_ignore_len got=%0d exp=%0d", n, exp_busy(8'h03));
    end
    peek("busy_ignored_10", 8'h10, model_word(8'h10));
    peek("busy_first_03", 8'h03, 32'hCAFE_F00D);
    model_write(8'h10, 32'h0BAD_BEEF, 4'b1111);
    tick();
    start = 1'b0;
    checks++;
    if (ready !== 1'b0) begin
      failures++;
      $display("FAIL second_accept got ready=%b exp=0", ready);
    end
    n = 0;
    while (ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    peek("second_write_10", 8'h10, 32'h0BAD_BEEF);
  endtask

  task automatic test_back_to_back();
    logic        rd;
    logic [7:0]  a;
    for (int i = 0; i < 12; i++) begin
      rd = 1'($urandom_range(0, 1));
      a  = 8'($urandom_range(0, 255));
      req(rd, a, $urandom, 4'($urandom_range(0, 15)));
    end
    peek("b2b_model", 8'hFD, model_word(8'hFD));
  endtask

  task automatic test_reset_busy();
    start = 1'b1; rwn = 1'b0; address = 8'h40; data_in = 32'h7777_7777; byte_en = 4'b1111;
    tick();
    start = 1'b0;
    checks++;
    if (ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy_accept got ready=%b exp=0", ready);
    end
    reset = 1'b0;
    for (int i = 0; i < 256; i++) model[i] = 8'h00;
    #1;
    checks++;
    if (ready !== 1'b1 || rvalid !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy_outputs got ready=%b rvalid=%b exp ready=1 rvalid=0", ready, rvalid);
    end
    peek("reset_busy_40", 8'h40, 32'h0);
    peek("reset_clears_20", 8'h20, 32'h0);
    tick(); tick();
    reset = 1'b1;
    tick(); tick();
    peek("after_reset_40", 8'h40, 32'h0);
    req(1'b1, 8'h40, 32'h0, 4'b0000);
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_partial_write();
    test_wrap();
    test_start_while_busy();
    test_back_to_back();
    test_reset_busy();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d exp=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
